// File: rtl/next_pc_unit_if.sv
// Pipeline-side bundle for the next-PC unit: fetch/decode/execute inputs and
// the redirect/stall controls returned to the program counter and pipeline registers.
interface next_pc_unit_if;
  logic [31:0] PCResult;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic [4:0]  ID_RegRs;
  logic [4:0]  ID_RegRt;
  logic        EX_MemRead;
  logic [4:0]  EX_RegRt;
  logic        MemStallReq;
  logic [31:0] Address;
  logic        stall;
  logic        Flush_IFID;
  logic        Bubble_IDEX;

  modport master (
    output PCResult, BranchTaken, BranchTarget, Jump, JumpTarget,
           ID_RegRs, ID_RegRt, EX_MemRead, EX_RegRt, MemStallReq,
    input  Address, stall, Flush_IFID, Bubble_IDEX
  );

  modport slave (
    input  PCResult, BranchTaken, BranchTarget, Jump, JumpTarget,
           ID_RegRs, ID_RegRt, EX_MemRead, EX_RegRt, MemStallReq,
    output Address, stall, Flush_IFID, Bubble_IDEX
  );
endinterface

// File: rtl/next_pc_unit.sv
// Next-PC selection with load-use and memory-stall handling; redirects seen during a
// memory stall are parked and replayed afterwards. Define BRANCH_DELAY_SLOT_EN to never flush IF/ID.
module next_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000,
  parameter int unsigned PC_STEP      = 4
) (
  input logic           Clk,
  input logic           Reset,
  next_pc_unit_if.slave bus
);

  typedef enum logic [1:0] {RUN, MEMWAIT, REDIR_PEND} state_t;

  state_t      state, nextState;
  logic        PendValid, nextPendValid;
  logic [31:0] PendTarget, nextPendTarget;

  logic        redirect;
  logic [31:0] redirTarget;
  logic        hazard;
  logic [31:0] seqAddr;
  logic [31:0] addrSel;
  logic        stallSel;
  logic        flushSel;
  logic        bubbleSel;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= RUN;
      PendValid  <= 1'b0;
      PendTarget <= 32'h0;
    end else begin
      state      <= nextState;
      PendValid  <= nextPendValid;
      PendTarget <= nextPendTarget;
    end
  end

  always_comb begin
    redirect    = bus.BranchTaken | bus.Jump;
    redirTarget = bus.BranchTaken ? bus.BranchTarget : bus.JumpTarget;
    hazard      = bus.EX_MemRead && (bus.EX_RegRt != 5'd0) &&
                  ((bus.EX_RegRt == bus.ID_RegRs) || (bus.EX_RegRt == bus.ID_RegRt));
    seqAddr     = bus.PCResult + 32'(PC_STEP);
  end

  // A live redirect always beats a parked one; a memory stall beats everything.
  always_comb begin
    nextState      = state;
    nextPendValid  = PendValid;
    nextPendTarget = PendTarget;
    addrSel        = seqAddr;
    stallSel       = 1'b0;
    flushSel       = 1'b0;
    bubbleSel      = 1'b0;

    if (bus.MemStallReq) begin
      stallSel  = 1'b1;
      nextState = MEMWAIT;
      if (redirect) begin
        nextPendValid  = 1'b1;
        nextPendTarget = redirTarget;
      end
    end else if (redirect) begin
      addrSel       = redirTarget;
      flushSel      = 1'b1;
      nextState     = RUN;
      nextPendValid = 1'b0;
    end else if (state == REDIR_PEND) begin
      addrSel       = PendTarget;
      flushSel      = 1'b1;
      nextState     = RUN;
      nextPendValid = 1'b0;
    end else begin
      if (hazard) begin
        stallSel  = 1'b1;
        bubbleSel = 1'b1;
      end
      nextState = (state == MEMWAIT && PendValid) ? REDIR_PEND : RUN;
    end
  end

  always_comb begin
    if (Reset) begin
      bus.Address     = RESET_VECTOR;
      bus.stall       = 1'b0;
      bus.Flush_IFID  = 1'b0;
      bus.Bubble_IDEX = 1'b0;
    end else begin
      bus.Address     = addrSel;
      bus.stall       = stallSel;
`ifdef BRANCH_DELAY_SLOT_EN
      bus.Flush_IFID  = 1'b0;
`else
      bus.Flush_IFID  = flushSel;
`endif
      bus.Bubble_IDEX = bubbleSel;
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit; expected values are hand-computed.
module tb_next_pc_unit;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DelaySlot = 1'b1;
`else
  localparam bit DelaySlot = 1'b0;
`endif

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  next_pc_unit_if bus ();

  next_pc_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic expectAll(input string tag, input logic [31:0] addr, input logic st,
                           input logic fl, input logic bu);
    checkOutput({tag, ".addr"}, bus.Address, addr);
    checkOutput({tag, ".stall"}, 32'(bus.stall), 32'(st));
    checkOutput({tag, ".flush"}, 32'(bus.Flush_IFID), 32'(fl & ~DelaySlot));
    checkOutput({tag, ".bubble"}, 32'(bus.Bubble_IDEX), 32'(bu));
  endtask

  task automatic expectStall(input string tag, input logic st);
    checkOutput({tag, ".stall"}, 32'(bus.stall), 32'(st));
    checkOutput({tag, ".flush"}, 32'(bus.Flush_IFID), 32'd0);
    checkOutput({tag, ".bubble"}, 32'(bus.Bubble_IDEX), 32'd0);
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic bt, input logic [31:0] btgt,
                               input logic j, input logic [31:0] jtgt, input logic [4:0] rs,
                               input logic [4:0] rt, input logic memRead, input logic [4:0] exRt,
                               input logic memStall);
    bus.PCResult     = pc;
    bus.BranchTaken  = bt;
    bus.BranchTarget = btgt;
    bus.Jump         = j;
    bus.JumpTarget   = jtgt;
    bus.ID_RegRs     = rs;
    bus.ID_RegRt     = rt;
    bus.EX_MemRead   = memRead;
    bus.EX_RegRt     = exRt;
    bus.MemStallReq  = memStall;
    #2;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;

    // Reset dominates even with a redirect and a stall request present
    applyStimulus(32'h10, 1'b1, 32'h200, 1'b0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
    expectAll("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    Reset = 1'b0;

    applyStimulus(32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
    expectAll("seq", 32'h14, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(32'hFFFFFFFC, 1'b0, 32'h0, 1'b0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
    expectAll("wrap", 32'h0, 1'b0, 1'b0, 1'b0);
    tick();

    // Load-use hazards
    applyStimulus(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 5'd5, 5'd2, 1'b1, 5'd5, 1'b0);
    expectAll("hazRs", 32'h44, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd2, 1'b1, 5'd0, 1'b0);
    expectAll("hazR0", 32'h44, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 5'd3, 5'd7, 1'b1, 5'd7, 1'b0);
    expectAll("hazRt", 32'h44, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 5'd3, 5'd7, 1'b0, 5'd7, 1'b0);
    expectAll("noLoad", 32'h44, 1'b0, 1'b0, 1'b0);
    tick();

    // Branch beats jump and hazard
    applyStimulus(32'h40, 1'b1, 32'h200, 1'b1, 32'h300, 5'd5, 5'd2, 1'b1, 5'd5, 1'b0);
    expectAll("brPrio", 32'h200, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(32'h40, 1'b0, 32'h200, 1'b1, 32'h300, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
    expectAll("jump", 32'h300, 1'b0, 1'b1, 1'b0);
    tick();

    // Branch parked during a 3-cycle memory stall, replayed afterwards
    applyStimulus(32'h50, 1'b0, 32'h0, 1'b0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1);
    expectStall("mw1", 1'b1);
    tick();
    applyStimulus(32'h50, 1'b1, 32'h80, 1'b0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1);
    expectStall("mw2", 1'b1);
    tick();
    applyStimulus(32'h50, 1'b0, 32'h0, 1'b0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1);
    expectStall("mw3", 1'b1);
    tick();
    applyStimulus(32'h50, 1'b0, 32'h0, 1'b0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
    expectAll("mwExit", 32'h54, 1'b0, 1'b0, 1'b0);
    tick();
    expectAll("replay", 32'h80, 1'b0, 1'b1, 1'b0);
    tick();
    expectAll("afterReplay", 32'h54, 1'b0, 1'b0, 1'b0);
    tick();

    // Newer redirect during a stall overwrites the parked one; live redirect beats replay
    applyStimulus(32'h60, 1'b1, 32'h100, 1'b0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1);
    tick();
    applyStimulus(32'h60, 1'b0, 32'h0, 1'b1, 32'h180, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1);
    expectStall("ovr", 1'b1);
    tick();
    applyStimulus(32'h60, 1'b0, 32'h0, 1'b0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
    tick();
    expectAll("ovrReplay", 32'h180, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(32'h60, 1'b1, 32'h120, 1'b0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1);
    tick();
    applyStimulus(32'h60, 1'b0, 32'h0, 1'b0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(32'h60, 1'b0, 32'h0, 1'b1, 32'h300, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
    expectAll("pendNew", 32'h300, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(32'h60, 1'b0, 32'h0, 1'b0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
    expectAll("pendCleared", 32'h64, 1'b0, 1'b0, 1'b0);
    tick();

    // Asynchronous reset in MEMWAIT with a parked redirect
    applyStimulus(32'h70, 1'b1, 32'h90, 1'b0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1);
    tick();
    applyStimulus(32'h70, 1'b0, 32'h0, 1'b0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1);
    expectStall("preRst", 1'b1);
    Reset = 1'b1;
    #1;
    expectAll("asyncRst", 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    Reset = 1'b0;
    applyStimulus(32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
    expectAll("postRst", 32'h14, 1'b0, 1'b0, 1'b0);
    tick();
    expectAll("noReplay", 32'h14, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
Parameters:
REQ-001 The block SHALL have parameter RESET_VECTOR, default 32'h00000000, meaning the Address value driven while Reset is high.
REQ-002 The block SHALL have parameter PC_STEP, default 4, meaning the sequential PC increment in bytes.
Ports:
REQ-003 Clk  in  1  the single clock; all state updates on posedge Clk.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 PCResult  in  32  current PC, registered by the program counter.
REQ-006 BranchTaken  in  1  / BranchTarget  in  32  resolved taken branch from EX.
REQ-007 Jump  in  1  / JumpTarget  in  32  jump decoded in ID.
REQ-008 ID_RegRs, ID_RegRt  in  5 each  source registers of the instruction in ID.
REQ-009 EX_MemRead  in  1  / EX_RegRt  in  5  load in EX and its destination register.
REQ-010 MemStallReq  in  1  instruction/data memory busy; the pipeline holds while high.
REQ-011 Address  out  32  next-PC value for the program counter.
REQ-012 stall  out  1  hold the program counter and the IF/ID register.
REQ-013 Flush_IFID  out  1  squash the instruction in IF/ID.
REQ-014 Bubble_IDEX  out  1  insert a NOP into ID/EX.

Function
REQ-015 FSM states SHALL be RUN, MEMWAIT, and REDIR_PEND; the state, PendValid and PendTarget[31:0] SHALL be the only registers.
REQ-016 Redirect SHALL mean BranchTaken or Jump; BranchTaken SHALL have priority over Jump, so the target is BranchTarget when both are high.
REQ-017 Load-use hazard SHALL mean EX_MemRead && EX_RegRt!=0 && (EX_RegRt==ID_RegRs || EX_RegRt==ID_RegRt), evaluated combinationally.
REQ-018 RUN, no event: Address=PCResult+PC_STEP (mod 2^32; wrap 32'hFFFFFFFC->0); stall=0, Flush_IFID=0, Bubble_IDEX=0.
REQ-019 RUN, redirect, MemStallReq=0: Address=target in the same cycle, Flush_IFID=1, stall=0; the state SHALL remain RUN.
REQ-020 RUN, hazard, no redirect, MemStallReq=0: stall=1 and Bubble_IDEX=1 for exactly that cycle; Address=PCResult+PC_STEP.
REQ-021 Redirect and hazard in the same cycle: the redirect SHALL win, so stall=0 and Bubble_IDEX=0.
REQ-022 MemStallReq=1 in any state: stall=1, Flush_IFID=0, Bubble_IDEX=0; RUN->MEMWAIT.
REQ-023 A redirect while MemStallReq=1 SHALL load PendTarget and set PendValid on the next edge, overwriting any older pending target.
REQ-024 MEMWAIT, MemStallReq falls: with PendValid set, go to REDIR_PEND; otherwise go to RUN.
REQ-025 REDIR_PEND: hold for one cycle with Address=PendTarget, Flush_IFID=1, stall=0; then clear PendValid and go to RUN.
REQ-026 A new redirect in REDIR_PEND SHALL take precedence over PendTarget, and PendValid SHALL still clear.
REQ-027 Outputs SHALL be combinational from the state, the pending registers and the inputs, with zero-cycle latency from input to output.

Reset
REQ-028 While Reset=1: state=RUN, PendValid=0, PendTarget=0, Address=RESET_VECTOR, stall=0, Flush_IFID=0, Bubble_IDEX=0.
REQ-029 Reset asserted mid-operation, including MEMWAIT or REDIR_PEND, SHALL discard any pending redirect immediately, without waiting for a clock edge.

Configuration
REQ-030 Macro BRANCH_DELAY_SLOT_EN SHALL control delay-slot behaviour.
- Defined: the instruction after a branch or jump executes; Flush_IFID SHALL never assert, and the redirect Address timing is unchanged.
- Undefined: Flush_IFID SHALL behave per REQ-019/025.

Verification
REQ-031 Reset pulse mid-MEMWAIT with PendValid=1 -> Address=0 and stall=0 at once; PendValid=0; after release PCResult=0x10 gives Address=0x14.
REQ-032 PCResult=0x40, EX_MemRead=1, EX_RegRt=5, ID_RegRs=5 -> stall=1, Bubble_IDEX=1 for 1 cycle; the same with EX_RegRt=0 -> no stall.
REQ-033 BranchTaken=1 with BranchTarget=0x200, Jump=1 with JumpTarget=0x300, and the hazard true, all in one cycle -> Address=0x200, Flush_IFID=1, stall=0.
REQ-034 MemStallReq high for 3 cycles; in cycle 2 BranchTaken with target 0x80 -> stall=1 for 3 cycles; then one cycle with Address=0x80 and Flush_IFID=1; then Address=PCResult+4.
REQ-035 PCResult=0xFFFFFFFC, no events -> Address=0x00000000.
REQ-036 With BRANCH_DELAY_SLOT_EN defined, rerun REQ-033/034 -> identical Address; Flush_IFID stays 0.
